// File: rtl/half16_norm_round.sv
// Normalize, round-to-nearest-even and pack a raw half-precision add/sub magnitude word
// into IEEE-754 binary16 plus flags; left normalization advances one bit per cycle.
module half16_norm_round #(
    parameter int unsigned EXP_W  = 5,
    parameter int unsigned FRAC_W = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exp_half,
    input  logic [FRAC_W+1:0]         in_mant_half,
    input  logic [2:0]                in_grs,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     q,
    output logic [4:0]                flags
);

    localparam int unsigned MANT_W  = FRAC_W + 2;
    localparam int unsigned EXP_RW  = EXP_W + 1;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;
    localparam int unsigned Q_W     = EXP_W + FRAC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t              state;
    logic [MANT_W-1:0]   mant;
    logic [EXP_RW-1:0]   exp;
    logic                g, r, s, sign;

    logic                round_up_c;
    logic                inexact_c;
    logic [MANT_W-1:0]   mant_rnd_c;
    logic [EXP_RW-1:0]   exp_rnd_c;
    logic [Q_W-1:0]      q_c;
    logic [4:0]          flags_c;

    // Round-to-nearest-even on the normalized word and pack the result
    always_comb begin
        round_up_c = g & (r | s | mant[0]);
        inexact_c  = g | r | s;
        mant_rnd_c = mant + MANT_W'(round_up_c);
        exp_rnd_c  = exp;
        q_c        = '0;
        flags_c    = '0;
        if (mant_rnd_c[MANT_W-1]) begin
            mant_rnd_c = MANT_W'(1) << FRAC_W;
            exp_rnd_c  = exp + EXP_RW'(1);
        end
        if (exp_rnd_c >= EXP_RW'(EXP_MAX)) begin
            q_c     = {sign, EXP_W'(EXP_MAX), FRAC_W'(0)};
            flags_c = 5'b00011;
        end else begin
            q_c        = {sign,
                          mant_rnd_c[FRAC_W] ? exp_rnd_c[EXP_W-1:0] : EXP_W'(0),
                          mant_rnd_c[FRAC_W-1:0]};
            flags_c[0] = inexact_c;
            flags_c[2] = ~mant_rnd_c[FRAC_W] & inexact_c;
            flags_c[3] = (q_c[Q_W-2:0] == '0);
        end
    end

    // Control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            flags     <= '0;
            mant      <= '0;
            exp       <= '0;
            g         <= 1'b0;
            r         <= 1'b0;
            s         <= 1'b0;
            sign      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sign     <= in_sign;
                        mant     <= in_mant_half;
                        exp      <= (in_exp_half == '0) ? EXP_RW'(1) : {1'b0, in_exp_half};
                        g        <= in_grs[2];
                        r        <= in_grs[1];
                        s        <= in_grs[0];
                        in_ready <= 1'b0;
                        state    <= S_NORM;
                    end
                end
                S_NORM: begin
                    // Shifting never clears a nonzero word, so all-zero can only be the captured input
                    if (mant == '0 && !g && !r && !s) begin
                        q         <= {sign, (Q_W-1)'(0)};
                        flags     <= 5'b01000;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (mant[MANT_W-1]) begin
                        mant  <= {1'b0, mant[MANT_W-1:1]};
                        g     <= mant[0];
                        r     <= g;
                        s     <= r | s;
                        exp   <= exp + EXP_RW'(1);
                        state <= S_ROUND;
                    end else if (mant[FRAC_W] || exp == EXP_RW'(1)) begin
                        state <= S_ROUND;
                    end else begin
                        mant <= {mant[MANT_W-2:0], g};
                        g    <= r;
                        r    <= 1'b0;
                        exp  <= exp - EXP_RW'(1);
                    end
                end
                S_ROUND: begin
                    q         <= q_c;
                    flags     <= flags_c;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half16_norm_round.sv
// Self-checking bench for half16_norm_round: directed table, handshake/reset sequences,
// and randomized words against an arithmetic RNE reference model.
module tb_half16_norm_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [4:0]  in_exp_half = '0;
    logic [11:0] in_mant_half = '0;
    logic [2:0]  in_grs = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] q;
    logic [4:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    half16_norm_round dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp_half  (in_exp_half),
        .in_mant_half (in_mant_half),
        .in_grs       (in_grs),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .q            (q),
        .flags        (flags)
    );

    typedef struct {
        logic        sign;
        logic [4:0]  e;
        logic [11:0] m;
        logic [2:0]  grs;
        logic [15:0] q;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Value-level reference: treat {mant,g,r} as an integer with a sticky tail, normalize by
    // leading-one position (floored at exponent 1), then apply round-half-to-even.
    function automatic void model(input logic sg, input logic [4:0] e_in, input logic [11:0] m,
                                  input logic [2:0] grs, output logic [15:0] rq,
                                  output logic [4:0] rfl, output int lat);
        int e, up, st, msb, n, kept, rem;
        logic inexact;
        e = (e_in == 0) ? 1 : int'(e_in);
        n = 0;
        if (m == 0 && grs == 0) begin
            rq  = {sg, 15'h0};
            rfl = 5'b01000;
            lat = 1;
            return;
        end
        up = int'({m, grs[2:1]});
        st = int'(grs[0]);
        if (m[11]) begin
            st = st | (up & 1);
            up = up >> 1;
            e  = e + 1;
        end else begin
            msb = -1;
            for (int i = 0; i < 14; i++) if (((up >> i) & 1) != 0) msb = i;
            n = (msb < 0) ? e - 1 : 12 - msb;
            if (n > e - 1) n = e - 1;
            up = up << n;
            e  = e - n;
        end
        kept = up >> 2;
        rem  = (up & 3) * 2 + st;
        if (rem > 4 || (rem == 4 && (kept % 2) == 1)) kept++;
        if (kept == 2048) begin
            kept = 1024;
            e++;
        end
        inexact = (rem != 0);
        if (e >= 31) begin
            rq  = {sg, 5'h1F, 10'h0};
            rfl = 5'b00011;
        end else begin
            rq  = {sg, (kept >= 1024) ? 5'(e) : 5'd0, 10'(kept)};
            rfl = {1'b0, rq[14:0] == 15'h0, (kept < 1024) && inexact, 1'b0, inexact};
        end
        lat = 2 + n;
    endfunction

    task automatic do_op(input logic sg, input logic [4:0] e, input logic [11:0] m,
                         input logic [2:0] grs, input logic [15:0] eq, input logic [4:0] ef,
                         input int elat, input int hold, input string name);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        in_sign = sg; in_exp_half = e; in_mant_half = m; in_grs = grs; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        chk({name, "_latency"}, 32'(cyc), 32'(elat));
        chk({name, "_q"}, 32'(q), 32'(eq));
        chk({name, "_flags"}, 32'(flags), 32'(ef));
        repeat (hold) begin
            @(posedge clk); #1;
        end
        if (hold > 0) chk({name, "_q_held"}, 32'({out_valid, q}), 32'({1'b1, eq}));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_valid_drop"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        logic [15:0] rq;
        logic [4:0]  rfl;
        int          lat, cyc, saw_valid;
        logic        stable;
        logic        sg;
        logic [4:0]  e;
        logic [11:0] m;
        logic [2:0]  grs;

        vecs[0] = '{1'b0, 5'd15, 12'h400, 3'b000, 16'h3C00, 5'b00000, 2};
        vecs[1] = '{1'b0, 5'd15, 12'h801, 3'b000, 16'h4000, 5'b00001, 2};
        vecs[2] = '{1'b0, 5'd15, 12'h001, 3'b000, 16'h1400, 5'b00000, 12};
        vecs[3] = '{1'b0, 5'd3,  12'h010, 3'b001, 16'h0040, 5'b00101, 4};
        vecs[4] = '{1'b1, 5'd30, 12'hFFF, 3'b000, 16'hFC00, 5'b00011, 2};
        vecs[5] = '{1'b1, 5'd7,  12'h000, 3'b000, 16'h8000, 5'b01000, 1};
        vecs[6] = '{1'b0, 5'd0,  12'h3FF, 3'b100, 16'h0400, 5'b00001, 2};
        vecs[7] = '{1'b0, 5'd20, 12'h000, 3'b100, 16'h2400, 5'b00000, 13};
        vecs[8] = '{1'b0, 5'd15, 12'h7FF, 3'b110, 16'h4000, 5'b00001, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'({in_ready, out_valid, q, flags}), 32'({1'b1, 1'b0, 16'h0, 5'h0}));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].sign, vecs[i].e, vecs[i].m, vecs[i].grs, vecs[i].q, vecs[i].fl,
                  vecs[i].lat, i % 2, $sformatf("vec%0d", i));
        end

        // Zero result held under back-pressure, then reset in the middle of a long normalization
        in_sign = 1'b1; in_exp_half = 5'd9; in_mant_half = '0; in_grs = '0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("zero_not_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("zero_result", 32'({out_valid, q, flags}), 32'({1'b1, 16'h8000, 5'b01000}));
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (!(out_valid && !in_ready && q == 16'h8000 && flags == 5'b01000)) stable = 1'b0;
        end
        chk("zero_held_5", 32'(stable), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_sign = 1'b0; in_exp_half = 5'd15; in_mant_half = 12'h001; in_grs = '0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("mid_reset_outs", 32'({out_valid, q, flags}), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_ready", 32'(in_ready), 32'd1);
        saw_valid = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid++;
        end
        chk("mid_reset_no_valid", 32'(saw_valid), 32'd0);

        for (int i = 0; i < 200; i++) begin
            sg  = 1'(($urandom));
            e   = 5'($urandom_range(0, 31));
            m   = 12'($urandom) >> $urandom_range(0, 12);
            grs = 3'($urandom);
            model(sg, e, m, grs, rq, rfl, lat);
            cyc = int'($urandom_range(0, 2));
            do_op(sg, e, m, grs, rq, rfl, lat, cyc, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
